// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch flush and optional HALT freeze (HAZARD_HALT_EN).
module hazard_stall_controller #(
  parameter int          REG_AW       = 5,
  parameter int          LOAD_LATENCY = 1,
  parameter int          CNT_W        = 16,
  parameter logic [5:0]  HALT_OP      = 6'b010101
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic [REG_AW-1:0] I_ID_RS,
  input  logic [REG_AW-1:0] I_ID_RT,
  input  logic              I_ID_USES_RT,
  input  logic [5:0]        I_OPCODE,
  input  logic [REG_AW-1:0] I_EXE_RT,
  input  logic              I_EXE_MEMREAD,
  input  logic              I_BRANCH_TAKEN,
  input  logic              I_CNT_CLR,
  output logic              O_PC_WRITE,
  output logic              O_IFID_WRITE,
  output logic              O_ID_CTRL_MUX,
  output logic              O_IFID_FLUSH,
  output logic              O_STALLED,
  output logic              O_HALTED,
  output logic [CNT_W-1:0]  O_STALL_CYCLES
);
  localparam int RW = $clog2(LOAD_LATENCY + 1);
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 8) begin : g_bad_latency
    $error("LOAD_LATENCY must be 1..8");
  end
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
  state_t          state;
  logic [RW-1:0]   rem;
  logic            hz, halt_op, stall_c, halt_c, freeze;
  assign hz = I_EXE_MEMREAD && (I_EXE_RT != '0) &&
              ((I_EXE_RT == I_ID_RS) || (I_ID_USES_RT && (I_EXE_RT == I_ID_RT)));
`ifdef HAZARD_HALT_EN
  assign halt_op = I_OPCODE == HALT_OP;
  assign halt_c  = I_RST_N && (state == HALT);
`else
  assign halt_op = 1'b0 && (I_OPCODE == HALT_OP);
  assign halt_c  = 1'b0;
`endif
  // Reset forces the pass-through outputs even while hazard inputs are live
  assign stall_c        = I_RST_N && !I_BRANCH_TAKEN && (((state == RUN) && hz) || (state == STALL));
  assign freeze         = stall_c || halt_c;
  assign O_PC_WRITE     = !freeze;
  assign O_IFID_WRITE   = !freeze;
  assign O_ID_CTRL_MUX  = freeze;
  assign O_IFID_FLUSH   = I_RST_N && I_BRANCH_TAKEN && (state != HALT);
  assign O_STALLED      = stall_c;
  assign O_HALTED       = halt_c;
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state          <= RUN;
      rem            <= '0;
      O_STALL_CYCLES <= '0;
    end else begin
      O_STALL_CYCLES <= I_CNT_CLR ? '0 :
                        (stall_c && (O_STALL_CYCLES != '1)) ? O_STALL_CYCLES + CNT_W'(1) : O_STALL_CYCLES;
      case (state)
        RUN: begin
          if (!I_BRANCH_TAKEN && hz && (LOAD_LATENCY > 1)) begin
            state <= STALL;
            rem   <= RW'(LOAD_LATENCY - 1);
          end else if (!I_BRANCH_TAKEN && !hz && halt_op) begin
            state <= HALT;
          end
        end
        STALL: begin
          if (I_BRANCH_TAKEN || (rem == RW'(1))) begin
            state <= RUN;
            rem   <= '0;
          end else begin
            rem <= rem - RW'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed checks on three parameterisations sharing one stimulus.
module tb_hazard_stall_controller;
  logic       clk = 1'b0, rst_n;
  logic [4:0] id_rs, id_rt, exe_rt;
  logic       uses_rt, memread, br, clr;
  logic [5:0] opcode;
  logic [5:0] o0, o1, o2;
  logic [15:0] c0, c1;
  logic [3:0]  c2;
  int total = 0, bad = 0;
  localparam logic [5:0] NORM = 6'b110000, STL = 6'b001010, FLS = 6'b110100, HLT = 6'b001001;
  always #5 clk = ~clk;

  hazard_stall_controller #(.LOAD_LATENCY(1)) d0 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_ID_RS(id_rs), .I_ID_RT(id_rt), .I_ID_USES_RT(uses_rt),
    .I_OPCODE(opcode), .I_EXE_RT(exe_rt), .I_EXE_MEMREAD(memread), .I_BRANCH_TAKEN(br),
    .I_CNT_CLR(clr), .O_PC_WRITE(o0[5]), .O_IFID_WRITE(o0[4]), .O_ID_CTRL_MUX(o0[3]),
    .O_IFID_FLUSH(o0[2]), .O_STALLED(o0[1]), .O_HALTED(o0[0]), .O_STALL_CYCLES(c0));
  hazard_stall_controller #(.LOAD_LATENCY(3)) d1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_ID_RS(id_rs), .I_ID_RT(id_rt), .I_ID_USES_RT(uses_rt),
    .I_OPCODE(opcode), .I_EXE_RT(exe_rt), .I_EXE_MEMREAD(memread), .I_BRANCH_TAKEN(br),
    .I_CNT_CLR(clr), .O_PC_WRITE(o1[5]), .O_IFID_WRITE(o1[4]), .O_ID_CTRL_MUX(o1[3]),
    .O_IFID_FLUSH(o1[2]), .O_STALLED(o1[1]), .O_HALTED(o1[0]), .O_STALL_CYCLES(c1));
  hazard_stall_controller #(.LOAD_LATENCY(1), .CNT_W(4)) d2 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_ID_RS(id_rs), .I_ID_RT(id_rt), .I_ID_USES_RT(uses_rt),
    .I_OPCODE(opcode), .I_EXE_RT(exe_rt), .I_EXE_MEMREAD(memread), .I_BRANCH_TAKEN(br),
    .I_CNT_CLR(clr), .O_PC_WRITE(o2[5]), .O_IFID_WRITE(o2[4]), .O_ID_CTRL_MUX(o2[3]),
    .O_IFID_FLUSH(o2[2]), .O_STALLED(o2[1]), .O_HALTED(o2[0]), .O_STALL_CYCLES(c2));

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; exe_rt = 5'd0; uses_rt = 1'b0;
    memread = 1'b0; br = 1'b0; clr = 1'b0; opcode = 6'd0;
  endtask
  task automatic load_use(input logic [4:0] rt);
    memread = 1'b1; exe_rt = rt; id_rs = rt;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    idle(); rst_n = 1'b0; #2; rst_n = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); load_use(5'd5); br = 1'b0; #3;
    total++; if (o0 !== NORM) begin bad++; $display("FAIL reset_outs0 got=%b exp=%b", o0, NORM); end
    total++; if (o1 !== NORM) begin bad++; $display("FAIL reset_outs1 got=%b exp=%b", o1, NORM); end
    br = 1'b1; #1;
    total++; if (o0[2] !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", o0[2]); end
    @(posedge clk); #1;
    total++; if (c0 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", c0); end
    idle(); rst_n = 1'b1; tick();
  endtask

  task automatic test_ll1();
    do_reset(); load_use(5'd5); #3;
    total++; if (o0 !== STL) begin bad++; $display("FAIL ll1_stall got=%b exp=%b", o0, STL); end
    tick(); idle(); #3;
    total++; if (o0 !== NORM) begin bad++; $display("FAIL ll1_release got=%b exp=%b", o0, NORM); end
    total++; if (c0 !== 16'd1) begin bad++; $display("FAIL ll1_cnt got=%0d exp=1", c0); end
    tick();
  endtask

  task automatic test_ll3_rt();
    do_reset(); memread = 1'b1; exe_rt = 5'd8; id_rt = 5'd8; uses_rt = 1'b1; id_rs = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #3;
      total++; if (o1 !== STL) begin bad++; $display("FAIL ll3_stall%0d got=%b exp=%b", i, o1, STL); end
      tick(); idle();
    end
    #3;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL ll3_release got=%b exp=%b", o1, NORM); end
    total++; if (c1 !== 16'd3) begin bad++; $display("FAIL ll3_cnt got=%0d exp=3", c1); end
    do_reset(); memread = 1'b1; exe_rt = 5'd8; id_rt = 5'd8; uses_rt = 1'b0; id_rs = 5'd3; #3;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL no_uses_rt got=%b exp=%b", o1, NORM); end
    tick(); idle(); memread = 1'b1; exe_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b1; #3;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL r0_no_stall got=%b exp=%b", o1, NORM); end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) load_use(5'd9);
      #3;
      total++; if (o1 !== STL) begin bad++; $display("FAIL b2b_stall%0d got=%b exp=%b", i, o1, STL); end
      tick(); idle();
    end
    #3;
    total++; if (c1 !== 16'd6) begin bad++; $display("FAIL b2b_cnt got=%0d exp=6", c1); end
    tick();
  endtask

  task automatic test_branch_abort();
    do_reset(); load_use(5'd7); #3;
    total++; if (o1 !== STL) begin bad++; $display("FAIL abort_first got=%b exp=%b", o1, STL); end
    tick(); idle(); br = 1'b1; #3;
    total++; if (o1 !== FLS) begin bad++; $display("FAIL abort_flush got=%b exp=%b", o1, FLS); end
    tick(); idle(); #3;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL abort_run got=%b exp=%b", o1, NORM); end
    total++; if (c1 !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d exp=1", c1); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset(); load_use(5'd4); br = 1'b1; #3;
    total++; if (o0 !== FLS) begin bad++; $display("FAIL same_ll1 got=%b exp=%b", o0, FLS); end
    total++; if (o1 !== FLS) begin bad++; $display("FAIL same_ll3 got=%b exp=%b", o1, FLS); end
    tick(); idle(); #3;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL same_after got=%b exp=%b", o1, NORM); end
    total++; if (c0 !== 16'd0) begin bad++; $display("FAIL same_cnt got=%0d exp=0", c0); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset(); load_use(5'd6);
    for (int i = 0; i < 20; i++) tick();
    #3;
    total++; if (c2 !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", c2); end
    clr = 1'b1; tick(); clr = 1'b0; #3;
    total++; if (c2 !== 4'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", c2); end
    tick(); #3;
    total++; if (c2 !== 4'd1) begin bad++; $display("FAIL post_clr_cnt got=%0d exp=1", c2); end
    idle(); tick();
  endtask

  task automatic test_halt();
    do_reset(); opcode = 6'b010101; #3;
    total++; if (o0 !== NORM) begin bad++; $display("FAIL halt_issue got=%b exp=%b", o0, NORM); end
    tick(); opcode = 6'd0;
`ifdef HAZARD_HALT_EN
    for (int i = 0; i < 10; i++) begin
      br = i[0]; load_use(5'd5); #3;
      total++; if (o0 !== HLT) begin bad++; $display("FAIL halt_hold%0d got=%b exp=%b", i, o0, HLT); end
      tick();
    end
    #3;
    total++; if (c0 !== 16'd0) begin bad++; $display("FAIL halt_cnt got=%0d exp=0", c0); end
    rst_n = 1'b0; #1;
    total++; if (o0 !== NORM) begin bad++; $display("FAIL halt_reset got=%b exp=%b", o0, NORM); end
    idle(); rst_n = 1'b1; tick();
`else
    #3;
    total++; if (o0 !== NORM) begin bad++; $display("FAIL halt_disabled got=%b exp=%b", o0, NORM); end
    tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0; idle();
    #1;
    test_reset();
    test_ll1();
    test_ll3_rt();
    test_back_to_back();
    test_branch_abort();
    test_same_cycle();
    test_saturate();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Parametrised load-use hazard and pipeline-freeze controller for the 5-stage MIPS core, sitting between the ID/EX decode logic and the PC, IF/ID, and ID/EX control mux. It extends plain load-use bubble insertion in four ways:
- Configurable multi-cycle load latency, with a stall counter.
- Register-0 and RT-usage qualification.
- Taken-branch IF/ID flush with defined priority.
- An optional sticky HALT freeze and a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- LOAD_LATENCY, 1: total stall cycles per load-use hazard; legal 1..8, anything else is an elaboration error.
- CNT_W, 16: width of the stall performance counter.
- HALT_OP, 6'b010101: opcode recognised as HALT.

Ports:
- I_CLK, in, 1: clock, rising edge.
- I_RST_N, in, 1: reset, asynchronous, active-low.
- I_ID_RS, in, REG_AW: RS field of the instruction in ID.
- I_ID_RT, in, REG_AW: RT field of the instruction in ID.
- I_ID_USES_RT, in, 1: the ID instruction reads RT as a source.
- I_OPCODE, in, 6: opcode of the instruction in ID.
- I_EXE_RT, in, REG_AW: destination RT of the instruction in EX.
- I_EXE_MEMREAD, in, 1: the EX instruction is a load.
- I_BRANCH_TAKEN, in, 1: a branch resolved taken this cycle.
- I_CNT_CLR, in, 1: synchronous clear of O_STALL_CYCLES.
- O_PC_WRITE, out, 1: PC write enable.
- O_IFID_WRITE, out, 1: IF/ID write enable.
- O_ID_CTRL_MUX, out, 1: 1 selects zeroed control (bubble) into ID/EX.
- O_IFID_FLUSH, out, 1: clears IF/ID to NOP.
- O_STALLED, out, 1: load-use stall active this cycle.
- O_HALTED, out, 1: core frozen by HALT.
- O_STALL_CYCLES, out, CNT_W: saturating count of load-use stall cycles.

## Operation
- State machine: RUN, STALL, HALT. Remaining-stall counter `rem` is $clog2(LOAD_LATENCY+1) bits wide.
- Hazard condition `hz`, all terms ANDed:
  - I_EXE_MEMREAD.
  - I_EXE_RT != 0.
  - (I_EXE_RT == I_ID_RS) or (I_ID_USES_RT and I_EXE_RT == I_ID_RT).
- RUN, evaluated in priority order:
  1. I_BRANCH_TAKEN: O_IFID_FLUSH=1 and PC writes; the hazard is ignored because the ID instruction is squashed.
  2. Else if hz: stall this cycle (O_PC_WRITE=0, O_IFID_WRITE=0, O_ID_CTRL_MUX=1, O_STALLED=1). If LOAD_LATENCY>1, go to STALL with rem=LOAD_LATENCY-1; otherwise stay in RUN.
  3. Else if I_OPCODE==HALT_OP (macro only): go to HALT. The HALT instruction itself advances normally this cycle.
  4. Else: normal pass-through (PC write 1, IF/ID write 1, mux 0).
- STALL: same stall outputs as a RUN hazard cycle, and rem decrements each cycle.
  - Return to RUN in the cycle rem==1.
  - hz is not re-evaluated while in STALL.
  - I_BRANCH_TAKEN in STALL aborts it: flush, PC writes, go to RUN, rem cleared.
- HALT: O_PC_WRITE=0, O_IFID_WRITE=0, O_ID_CTRL_MUX=1, O_HALTED=1.
  - Branch and hazard inputs are ignored.
  - Exit only by reset.
- O_STALL_CYCLES increments on each cycle with O_STALLED=1 and saturates at all-ones.
  - I_CNT_CLR has priority over increment; a clear and a stall in the same cycle gives 0.
  - HALT cycles are not counted.

## Timing
- Load-use hazard detection is combinational: the stall asserts in the same cycle hz is true.
- Each hazard produces exactly LOAD_LATENCY consecutive stall cycles, unless aborted by a taken branch.
- Flush is combinational in the same cycle as I_BRANCH_TAKEN.
- The HALT freeze begins in the cycle after HALT_OP is seen in ID.
- Asynchronous reset, while I_RST_N=0 and immediately after:
  - State RUN, rem=0, O_STALL_CYCLES=0, O_HALTED=0, O_STALLED=0, O_IFID_FLUSH=0.
  - O_PC_WRITE=1, O_IFID_WRITE=1, O_ID_CTRL_MUX=0 (combinational outputs forced to these values while in reset).
- Reset mid-STALL or mid-HALT returns to RUN with no residual stall.
- Reset is deasserted synchronously to I_CLK upstream.

## Configuration
- HAZARD_HALT_EN defined: HALT_OP detection and the HALT state are compiled in.
- HAZARD_HALT_EN undefined:
  - HALT_OP is treated as an ordinary opcode.
  - The HALT state is absent.
  - O_HALTED is tied 0.

## Test plan
- LOAD_LATENCY=1, EX load RT=5, ID RS=5: exactly 1 cycle with PC_WRITE=0 and CTRL_MUX=1, then free-running. O_STALL_CYCLES=1.
- LOAD_LATENCY=3, EX load RT=8, ID RT=8 with USES_RT=1: 3 consecutive stall cycles. With USES_RT=0: 0 stall cycles. With RT=0: 0 stall cycles.
- LOAD_LATENCY=3, hazard, then I_BRANCH_TAKEN in the 2nd stall cycle: the flush asserts in that same cycle, PC_WRITE=1 that cycle, and the state is RUN in the next cycle. O_STALL_CYCLES=1.
- Hazard and I_BRANCH_TAKEN in the same cycle: FLUSH=1, PC_WRITE=1, STALLED=0.
- HAZARD_HALT_EN defined, I_OPCODE=6'b010101: from the next cycle O_HALTED=1 and PC_WRITE=0, held for 10 cycles despite branches. Asserting I_RST_N=0 restores PC_WRITE=1 and HALTED=0.
- CNT_W=4: 20 stall cycles leave O_STALL_CYCLES=15. I_CNT_CLR together with a stall cycle gives 0.
